// File: rtl/pointer_sequencer_if.sv
// Command, memory and pointer-pair signals between decode, the sequencer and the pointer pair.
interface pointer_sequencer_if;
    logic        req;
    logic [2:0]  op;
    logic        busy;
    logic        ack;
    logic        err;
    logic [7:0]  mem_rdata;
    logic        mem_oe;
    logic        mem_we;
    logic [7:0]  rdata;
    logic [15:0] rdata16;
    logic        we_l;
    logic        we_h;
    logic        oe_addr_ip;
    logic        oe_addr_dp;
    logic        oe_dl;
    logic        oe_dh;
    logic        cnt;
    logic        selector;

    // Sequencer side
    modport master (
        input  req, op, mem_rdata,
        output busy, ack, err, mem_oe, mem_we, rdata, rdata16,
               we_l, we_h, oe_addr_ip, oe_addr_dp, oe_dl, oe_dh, cnt, selector
    );

    // Decode / pointer-pair / memory side
    modport slave (
        output req, op, mem_rdata,
        input  busy, ack, err, mem_oe, mem_we, rdata, rdata16,
               we_l, we_h, oe_addr_ip, oe_addr_dp, oe_dl, oe_dh, cnt, selector
    );
endinterface

// File: rtl/pointer_sequencer.sv
// Pointer-pair sequencer: turns decode commands into strobe sequences with one ack each.
module pointer_sequencer #(
    parameter int unsigned WAIT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    pointer_sequencer_if.master   bus
);
    localparam int unsigned WCNT_W    = 2;
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT);

    typedef enum logic [3:0] {
        S_IDLE,
        S_IP_RD,
        S_LD_L,
        S_LD_H,
        S_DP_RD,
        S_DP_WR,
        S_JMP,
        S_SV_L,
        S_SV_H,
        S_ERR
    } state_t;

    state_t              state, state_n;
    logic [WCNT_W-1:0]   wcnt, wcnt_n;
    logic                last_c;
    logic                last_n_c;
    logic                is_mem_c;
    logic                is_mem_n_c;

    // Next-state and wait-counter sequencing
    always_comb begin
        state_n  = state;
        wcnt_n   = '0;
        is_mem_c = (state == S_IP_RD) || (state == S_LD_L) || (state == S_LD_H) ||
                   (state == S_DP_RD) || (state == S_DP_WR);
        last_c   = !is_mem_c || (wcnt == WAIT_LAST);
        if (is_mem_c && !last_c) begin
            wcnt_n = wcnt + WCNT_W'(1);
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req) begin
                        case (bus.op)
                            3'd0:    state_n = S_IP_RD;
                            3'd1:    state_n = S_LD_L;
                            3'd2:    state_n = S_JMP;
                            3'd3:    state_n = S_DP_RD;
                            3'd4:    state_n = S_DP_WR;
                            3'd5:    state_n = S_SV_L;
                            default: state_n = S_ERR;
                        endcase
                    end
                end
                S_LD_L:  state_n = S_LD_H;
                S_SV_L:  state_n = S_SV_H;
                default: state_n = S_IDLE;
            endcase
        end
        is_mem_n_c = (state_n == S_IP_RD) || (state_n == S_LD_L) || (state_n == S_LD_H) ||
                     (state_n == S_DP_RD) || (state_n == S_DP_WR);
        last_n_c   = !is_mem_n_c || (wcnt_n == WAIT_LAST);
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            wcnt  <= '0;
        end else begin
            state <= state_n;
            wcnt  <= wcnt_n;
        end
    end

    // Registered strobes and handshake, decoded from the upcoming state and wait count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.busy       <= 1'b0;
            bus.ack        <= 1'b0;
            bus.err        <= 1'b0;
            bus.mem_oe     <= 1'b1;
            bus.mem_we     <= 1'b1;
            bus.we_l       <= 1'b1;
            bus.we_h       <= 1'b1;
            bus.oe_addr_ip <= 1'b1;
            bus.oe_addr_dp <= 1'b1;
            bus.oe_dl      <= 1'b1;
            bus.oe_dh      <= 1'b1;
            bus.cnt        <= 1'b0;
        end else begin
            bus.busy       <= (state_n != S_IDLE);
            bus.ack        <= (state_n != S_IDLE) && (state_n != S_LD_L) &&
                              (state_n != S_SV_L) && last_n_c;
            bus.err        <= (state_n == S_ERR);
            bus.mem_oe     <= !((state_n == S_IP_RD) || (state_n == S_LD_L) ||
                                (state_n == S_LD_H)  || (state_n == S_DP_RD));
            bus.mem_we     <= !(state_n == S_DP_WR);
            bus.we_l       <= !((state_n == S_LD_L) && last_n_c);
            bus.we_h       <= !((state_n == S_LD_H) && last_n_c);
            bus.oe_addr_ip <= !((state_n == S_IP_RD) || (state_n == S_LD_L) ||
                                (state_n == S_LD_H));
            bus.oe_addr_dp <= !((state_n == S_DP_RD) || (state_n == S_DP_WR));
            bus.oe_dl      <= !(state_n == S_SV_L);
            bus.oe_dh      <= !(state_n == S_SV_H);
            bus.cnt        <= ((state_n == S_IP_RD) || (state_n == S_LD_L) ||
                               (state_n == S_LD_H)) && last_n_c;
        end
    end

    // Data capture and IP/DP swap, taken at the end of the final cycle of each state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.rdata    <= '0;
            bus.rdata16  <= '0;
            bus.selector <= 1'b0;
        end else begin
            if (((state == S_IP_RD) || (state == S_DP_RD)) && last_c) begin
                bus.rdata <= bus.mem_rdata;
            end
            if (state == S_SV_L) begin
                bus.rdata16[7:0] <= bus.mem_rdata;
            end
            if (state == S_SV_H) begin
                bus.rdata16[15:8] <= bus.mem_rdata;
            end
            if (state == S_JMP) begin
                bus.selector <= ~bus.selector;
            end
        end
    end
endmodule

// File: tb/tb_pointer_sequencer.sv
// Directed bench: WAIT=0 sequencer driving a behavioural pointer pair + memory, and a WAIT=2 instance.
module tb_pointer_sequencer;
    logic clk;
    logic rst;

    int vectors;
    int miscompares;

    pointer_sequencer_if if0 ();
    pointer_sequencer_if if2 ();

    pointer_sequencer #(.WAIT(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    pointer_sequencer #(.WAIT(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural pointer pair and memory for the WAIT=0 instance
    logic [7:0]  mem [0:65535];
    logic [15:0] pa, pb;
    logic [15:0] ip_m, dp_m, addr_m;

    assign ip_m   = if0.selector ? pb : pa;
    assign dp_m   = if0.selector ? pa : pb;
    assign addr_m = !if0.oe_addr_ip ? ip_m : (!if0.oe_addr_dp ? dp_m : 16'h0000);

    always_comb begin
        if0.mem_rdata = 8'h00;
        if (!if0.mem_oe)     if0.mem_rdata = mem[addr_m];
        else if (!if0.oe_dl) if0.mem_rdata = dp_m[7:0];
        else if (!if0.oe_dh) if0.mem_rdata = dp_m[15:8];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pa <= 16'h0100;
            pb <= 16'h0000;
        end else begin
            if (if0.cnt) begin
                if (if0.selector) pb <= pb + 16'd1;
                else              pa <= pa + 16'd1;
            end
            if (!if0.we_l) begin
                if (if0.selector) pa[7:0] <= if0.mem_rdata;
                else              pb[7:0] <= if0.mem_rdata;
            end
            if (!if0.we_h) begin
                if (if0.selector) pa[15:8] <= if0.mem_rdata;
                else              pb[15:8] <= if0.mem_rdata;
            end
        end
    end

    function automatic logic [7:0] strb0();
        return {if0.mem_oe, if0.mem_we, if0.we_l, if0.we_h,
                if0.oe_addr_ip, if0.oe_addr_dp, if0.oe_dl, if0.oe_dh};
    endfunction

    function automatic logic [7:0] strb2();
        return {if2.mem_oe, if2.mem_we, if2.we_l, if2.we_h,
                if2.oe_addr_ip, if2.oe_addr_dp, if2.oe_dl, if2.oe_dh};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        if0.req = 1'b0; if0.op = 3'd0;
        if2.req = 1'b0; if2.op = 3'd0; if2.mem_rdata = 8'h00;
        mem[16'h0100] = 8'h3C;
        mem[16'h0101] = 8'h34;
        mem[16'h0102] = 8'h12;
        mem[16'h0103] = 8'hFE;
        mem[16'h0104] = 8'h00;
        mem[16'h0105] = 8'h11;
        mem[16'h0106] = 8'h22;
        mem[16'h0107] = 8'h33;
        mem[16'h1234] = 8'hA5;
        mem[16'h00FE] = 8'h77;

        // Reset state
        tick(); tick();
        chk("rst_strobes", 32'(strb0()), 32'hFF);
        chk("rst_busy", 32'(if0.busy), 32'd0);
        chk("rst_ack", 32'(if0.ack), 32'd0);
        chk("rst_err", 32'(if0.err), 32'd0);
        chk("rst_cnt", 32'(if0.cnt), 32'd0);
        chk("rst_sel", 32'(if0.selector), 32'd0);
        chk("rst_rdata", 32'(if0.rdata), 32'h00);
        chk("rst_rdata16", 32'(if0.rdata16), 32'h0000);
        chk("rst2_strobes", 32'(strb2()), 32'hFF);
        rst = 1'b1;
        tick();
        chk("idle_ack", 32'(if0.ack), 32'd0);

        // FETCH, WAIT=0
        if0.op = 3'd0; if0.req = 1'b1;
        tick();
        chk("fetch_strobes", 32'(strb0()), 32'h77);
        chk("fetch_ack", 32'(if0.ack), 32'd1);
        chk("fetch_cnt", 32'(if0.cnt), 32'd1);
        if0.req = 1'b0;
        tick();
        chk("fetch_ack_drop", 32'(if0.ack), 32'd0);
        chk("fetch_cnt_drop", 32'(if0.cnt), 32'd0);
        chk("fetch_rdata", 32'(if0.rdata), 32'h3C);
        chk("fetch_ip", 32'(ip_m), 32'h0101);
        chk("fetch_busy", 32'(if0.busy), 32'd0);

        // LOAD_DP 0x34, 0x12
        if0.op = 3'd1; if0.req = 1'b1;
        tick();
        chk("ldl_strobes", 32'(strb0()), 32'h57);
        chk("ldl_ack", 32'(if0.ack), 32'd0);
        chk("ldl_busy", 32'(if0.busy), 32'd1);
        if0.req = 1'b0;
        tick();
        chk("ldh_strobes", 32'(strb0()), 32'h67);
        chk("ldh_ack", 32'(if0.ack), 32'd1);
        tick();
        chk("ld_idle_strobes", 32'(strb0()), 32'hFF);
        chk("ld_dp", 32'(dp_m), 32'h1234);
        chk("ld_ip", 32'(ip_m), 32'h0103);
        chk("ld_rdata_kept", 32'(if0.rdata), 32'h3C);

        // READ_DP through DP=0x1234
        if0.op = 3'd3; if0.req = 1'b1;
        tick();
        chk("rd_strobes", 32'(strb0()), 32'h7B);
        chk("rd_ack", 32'(if0.ack), 32'd1);
        if0.req = 1'b0;
        tick();
        chk("rd_rdata", 32'(if0.rdata), 32'hA5);

        // WRITE_DP
        if0.op = 3'd4; if0.req = 1'b1;
        tick();
        chk("wr_strobes", 32'(strb0()), 32'hBB);
        chk("wr_ack", 32'(if0.ack), 32'd1);
        if0.req = 1'b0;
        tick();
        chk("wr_idle_strobes", 32'(strb0()), 32'hFF);

        // LOAD_DP 0xFE, 0x00 then SAVE_DP
        if0.op = 3'd1; if0.req = 1'b1;
        tick();
        if0.req = 1'b0;
        tick(); tick();
        chk("ld2_dp", 32'(dp_m), 32'h00FE);
        chk("ld2_ip", 32'(ip_m), 32'h0105);
        if0.op = 3'd5; if0.req = 1'b1;
        tick();
        chk("svl_strobes", 32'(strb0()), 32'hFD);
        chk("svl_ack", 32'(if0.ack), 32'd0);
        if0.req = 1'b0;
        tick();
        chk("svh_strobes", 32'(strb0()), 32'hFE);
        chk("svh_ack", 32'(if0.ack), 32'd1);
        tick();
        chk("sv_rdata16", 32'(if0.rdata16), 32'h00FE);
        chk("sv_busy", 32'(if0.busy), 32'd0);
        chk("sv_rdata_kept", 32'(if0.rdata), 32'hA5);

        // JUMP twice
        if0.op = 3'd2; if0.req = 1'b1;
        tick();
        chk("jmp1_strobes", 32'(strb0()), 32'hFF);
        chk("jmp1_cnt", 32'(if0.cnt), 32'd0);
        chk("jmp1_ack", 32'(if0.ack), 32'd1);
        if0.req = 1'b0;
        tick();
        chk("jmp1_sel", 32'(if0.selector), 32'd1);
        chk("jmp1_ack_drop", 32'(if0.ack), 32'd0);
        if0.req = 1'b1;
        tick();
        chk("jmp2_strobes", 32'(strb0()), 32'hFF);
        chk("jmp2_ack", 32'(if0.ack), 32'd1);
        if0.req = 1'b0;
        tick();
        chk("jmp2_sel", 32'(if0.selector), 32'd0);

        // Illegal op 7
        if0.op = 3'd7; if0.req = 1'b1;
        tick();
        chk("err_ack", 32'(if0.ack), 32'd1);
        chk("err_err", 32'(if0.err), 32'd1);
        chk("err_strobes", 32'(strb0()), 32'hFF);
        chk("err_cnt", 32'(if0.cnt), 32'd0);
        if0.req = 1'b0;
        tick();
        chk("err_drop", 32'(if0.err), 32'd0);

        // Back-to-back FETCH with req held high
        if0.op = 3'd0; if0.req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("b2b_ack", 32'(if0.ack), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("b2b_busy", 32'(if0.busy), (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        if0.req = 1'b0;
        tick();
        chk("b2b_ip", 32'(ip_m), 32'h0108);
        chk("b2b_rdata", 32'(if0.rdata), 32'h33);
        chk("b2b_err", 32'(if0.err), 32'd0);

        // Reset in the middle of LOAD_DP after a JUMP
        if0.op = 3'd2; if0.req = 1'b1;
        tick();
        if0.req = 1'b0;
        tick();
        chk("pre_rst_sel", 32'(if0.selector), 32'd1);
        if0.op = 3'd1; if0.req = 1'b1;
        tick();
        chk("pre_rst_strobes", 32'(strb0()), 32'h57);
        if0.req = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_strobes", 32'(strb0()), 32'hFF);
        chk("mid_rst_cnt", 32'(if0.cnt), 32'd0);
        chk("mid_rst_sel", 32'(if0.selector), 32'd0);
        chk("mid_rst_busy", 32'(if0.busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_ack", 32'(if0.ack), 32'd0);
            chk("post_rst_busy", 32'(if0.busy), 32'd0);
        end

        // WAIT=2 READ_DP: only the third cycle's bus value is captured
        if2.op = 3'd3; if2.req = 1'b1; if2.mem_rdata = 8'h11;
        tick();
        chk("w2rd_c1_strobes", 32'(strb2()), 32'h7B);
        chk("w2rd_c1_ack", 32'(if2.ack), 32'd0);
        if2.req = 1'b0; if2.mem_rdata = 8'h22;
        tick();
        chk("w2rd_c2_strobes", 32'(strb2()), 32'h7B);
        chk("w2rd_c2_ack", 32'(if2.ack), 32'd0);
        chk("w2rd_c2_rdata", 32'(if2.rdata), 32'h00);
        if2.mem_rdata = 8'h5A;
        tick();
        chk("w2rd_c3_strobes", 32'(strb2()), 32'h7B);
        chk("w2rd_c3_ack", 32'(if2.ack), 32'd1);
        chk("w2rd_c3_rdata", 32'(if2.rdata), 32'h00);
        tick();
        chk("w2rd_rdata", 32'(if2.rdata), 32'h5A);
        chk("w2rd_idle_strobes", 32'(strb2()), 32'hFF);
        chk("w2rd_ack_drop", 32'(if2.ack), 32'd0);

        // WAIT=2 FETCH: cnt only in the last of three cycles
        if2.op = 3'd0; if2.req = 1'b1; if2.mem_rdata = 8'hC3;
        tick();
        chk("w2f_c1_cnt", 32'(if2.cnt), 32'd0);
        chk("w2f_c1_strobes", 32'(strb2()), 32'h77);
        if2.req = 1'b0;
        tick();
        chk("w2f_c2_cnt", 32'(if2.cnt), 32'd0);
        chk("w2f_c2_ack", 32'(if2.ack), 32'd0);
        tick();
        chk("w2f_c3_cnt", 32'(if2.cnt), 32'd1);
        chk("w2f_c3_ack", 32'(if2.ack), 32'd1);
        tick();
        chk("w2f_cnt_drop", 32'(if2.cnt), 32'd0);
        chk("w2f_busy", 32'(if2.busy), 32'd0);
        chk("w2f_rdata", 32'(if2.rdata), 32'hC3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
